// File: rtl/multiplexeur_arbitre.sv
// N-to-1 streaming multiplexer with a registered output stage.
// The arbitration policy is chosen per cycle: round-robin, or fixed priority where the lowest index wins.
module multiplexeur_arbitre #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_sel
);

  localparam logic [SEL_W:0] CH_EXT = (SEL_W+1)'(CHANNELS);

  logic [WIDTH-1:0]    ch_data [CHANNELS];
  logic [SEL_W-1:0]    rot_idx [CHANNELS];
  logic [CHANNELS-1:0] rot_valid;

  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic [SEL_W-1:0] out_sel_reg, out_sel_next;
  logic             out_valid_reg, out_valid_next;

  logic [SEL_W-1:0] rr_grant, fp_grant, grant_idx;
  logic             any_valid, accept, xfer;

  // rot_idx[gi] is the channel visited at search step gi, starting just after ptr.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [SEL_W:0] sum;
      assign ch_data[gi]   = in_data[gi*WIDTH +: WIDTH];
      assign sum           = {1'b0, ptr_reg} + (SEL_W+1)'(gi + 1);
      assign rot_idx[gi]   = (sum >= CH_EXT) ? SEL_W'(sum - CH_EXT) : sum[SEL_W-1:0];
      assign rot_valid[gi] = in_valid[rot_idx[gi]];
    end
  endgenerate

  // Both searches run downward so the last hit written is the highest-priority one.
  always_comb begin
    rr_grant = ptr_reg;
    fp_grant = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rot_valid[i]) rr_grant = rot_idx[i];
      if (in_valid[i])  fp_grant = SEL_W'(i);
    end
  end

  assign grant_idx = mode ? fp_grant : rr_grant;
  assign any_valid = |in_valid;
  assign accept    = !out_valid_reg || out_ready;
  // Gating by rst keeps in_ready low while the block is held in reset.
  assign xfer      = accept && any_valid && !rst;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign in_ready[gi] = xfer && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    ptr_next       = ptr_reg;
    out_data_next  = out_data_reg;
    out_sel_next   = out_sel_reg;
    out_valid_next = out_valid_reg;
    if (xfer) begin
      ptr_next       = grant_idx;
      out_data_next  = ch_data[grant_idx];
      out_sel_next   = grant_idx;
      out_valid_next = 1'b1;
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // ptr resets to the last channel so the first round-robin search starts at channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg       <= SEL_W'(CHANNELS - 1);
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      ptr_reg       <= ptr_next;
      out_data_reg  <= out_data_next;
      out_sel_reg   <= out_sel_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_multiplexeur_arbitre.sv
// Scoreboard bench for multiplexeur_arbitre (CHANNELS=4, WIDTH=8).
// Expected words are queued by the stimulus; a negedge monitor pops one per output transfer.
module tb_multiplexeur_arbitre;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic        mode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  multiplexeur_arbitre #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [1:0] s, input logic [7:0] d);
    sb.push_back({s, d});
  endtask

  task automatic set_data(input logic [7:0] d3, input logic [7:0] d2,
                          input logic [7:0] d1, input logic [7:0] d0);
    in_data = {d3, d2, d1, d0};
  endtask

  // Monitor: an output transfer happens at the next posedge when both are high here.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_word: got sel=%0d data=%02h, required no word", out_sel, out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_word{sel,data}", {22'd0, out_sel, out_data}, {22'd0, mon_e.sel, mon_e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    set_data(8'hA3, 8'hA2, 8'hA1, 8'hA0);
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_out_sel",   {30'd0, out_sel},   32'd0);
    chk("rst_in_ready",  {28'd0, in_ready},  32'd0);

    // Round-robin over all four channels, starting at 0 after reset.
    rst = 1'b0;
    expect_word(2'd0, 8'hA0);
    expect_word(2'd1, 8'hA1);
    expect_word(2'd2, 8'hA2);
    expect_word(2'd3, 8'hA3);
    expect_word(2'd0, 8'hA0);
    repeat (5) step();
    in_valid = 4'h0;
    step();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_out_data",  {24'd0, out_data},  32'h0A0);
    chk("drain_out_sel",   {30'd0, out_sel},   32'd0);
    chk("rr_sb_empty",     sb.size(),          32'd0);

    // Fixed priority with channels 1 and 3 requesting; ptr is 0.
    mode     = 1'b1;
    in_valid = 4'b1010;
    set_data(8'hB3, 8'h00, 8'hB1, 8'h00);
    repeat (3) begin
      #1;
      chk("fp_in_ready", {28'd0, in_ready}, 32'b0010);
      expect_word(2'd1, 8'hB1);
      step();
    end
    mode = 1'b0;
    #1;
    chk("fp2rr_in_ready_a", {28'd0, in_ready}, 32'b1000);
    expect_word(2'd3, 8'hB3);
    step();
    chk("fp2rr_in_ready_b", {28'd0, in_ready}, 32'b0010);
    expect_word(2'd1, 8'hB1);
    step();
    in_valid = 4'h0;
    step();
    chk("fp_sb_empty", sb.size(), 32'd0);

    // Sparse traffic: only channel 2, then channels 2 and 3 alternate.
    in_valid = 4'b0100;
    set_data(8'hC3, 8'hC2, 8'h00, 8'h00);
    repeat (3) begin
      #1;
      chk("sparse_in_ready", {28'd0, in_ready}, 32'b0100);
      expect_word(2'd2, 8'hC2);
      step();
    end
    in_valid = 4'b1100;
    repeat (2) begin
      #1;
      chk("alt_in_ready_3", {28'd0, in_ready}, 32'b1000);
      expect_word(2'd3, 8'hC3);
      step();
      chk("alt_in_ready_2", {28'd0, in_ready}, 32'b0100);
      expect_word(2'd2, 8'hC2);
      step();
    end
    in_valid = 4'h0;
    step();
    chk("sparse_sb_empty", sb.size(), 32'd0);

    // Backpressure: hold 0x55 for five cycles, then release with no bubble.
    in_valid = 4'b0001;
    set_data(8'h00, 8'h00, 8'h00, 8'h55);
    #1;
    chk("bp_load_in_ready", {28'd0, in_ready}, 32'b0001);
    expect_word(2'd0, 8'h55);
    step();
    out_ready = 1'b0;
    in_valid  = 4'b0010;
    set_data(8'h00, 8'h00, 8'h66, 8'h55);
    repeat (5) begin
      #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_data",  {24'd0, out_data},  32'h55);
      chk("bp_out_sel",   {30'd0, out_sel},   32'd0);
      chk("bp_in_ready",  {28'd0, in_ready},  32'b0000);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {28'd0, in_ready}, 32'b0010);
    expect_word(2'd1, 8'h66);
    step();
    chk("bp_nogap_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_nogap_out_data",  {24'd0, out_data},  32'h66);
    in_valid = 4'h0;
    step();
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Reset mid-stream discards the held word; first grant afterwards is channel 0.
    mode      = 1'b0;
    out_ready = 1'b0;
    in_valid  = 4'hF;
    set_data(8'hA3, 8'hA2, 8'hA1, 8'hA0);
    #1;
    chk("pre_rst_in_ready", {28'd0, in_ready}, 32'b0100);
    step();
    chk("pre_rst_out_data", {24'd0, out_data}, 32'h0A2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data",  {24'd0, out_data},  32'd0);
    chk("mid_rst_out_sel",   {30'd0, out_sel},   32'd0);
    chk("mid_rst_in_ready",  {28'd0, in_ready},  32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    expect_word(2'd0, 8'hA0);
    expect_word(2'd1, 8'hA1);
    step();
    step();
    in_valid = 4'h0;
    step();
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("final_sb_empty",     sb.size(),          32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multiplexeur_arbitre.md
MULTIPLEXEUR_ARBITRE -- requirements
Module: multiplexeur_arbitre

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the data width of each channel in bits; legal range is 1..64.
REQ-002 The parameter CHANNELS SHALL default to 4 and set the number of input channels; legal range is 2..16.
REQ-003 The derived parameter SEL_W SHALL equal clog2(CHANNELS) and SHALL NOT be overridden.
REQ-004 The port clk SHALL be an input of width 1: the single clock, rising edge active.
REQ-005 The port rst SHALL be an input of width 1: asynchronous, active-high reset.
REQ-006 The port in_data SHALL be an input of width CHANNELS*WIDTH; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The port in_valid SHALL be an input of width CHANNELS: per-channel word-present flag.
REQ-008 The port in_ready SHALL be an output of width CHANNELS: per-channel accept strobe.
REQ-009 The port mode SHALL be an input of width 1: 0 selects round-robin, 1 selects fixed priority (lowest index wins).
REQ-010 The port out_data SHALL be an output of width WIDTH: registered selected word.
REQ-011 The port out_valid SHALL be an output of width 1: out_data holds a word.
REQ-012 The port out_ready SHALL be an input of width 1: sink accepts the word.
REQ-013 The port out_sel SHALL be an output of width SEL_W: index of the channel that supplied out_data.

Function
REQ-014 A transfer on channel k SHALL occur in a cycle where in_valid[k] and in_ready[k] are both 1 at the rising edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 The internal signal accept SHALL equal (!out_valid | out_ready), so the output register loads when it is empty or being drained in the same cycle.
REQ-016 in_ready SHALL be combinational, one-hot or zero, with in_ready[g]=1 only when accept=1, in_valid[g]=1 and g is the granted channel.
REQ-017 With mode=0, the grant SHALL go to the first channel with in_valid=1, searching upward from ptr+1 and wrapping modulo CHANNELS.
REQ-018 With mode=1, the grant SHALL go to the lowest-index channel with in_valid=1, independent of ptr.
REQ-019 The register ptr (SEL_W bits) SHALL load the granted index on every input transfer in either mode and SHALL hold otherwise, so a mode change takes effect on the next cycle without glitching.
REQ-020 mode SHALL be sampled combinationally every cycle.
REQ-021 On an input transfer, out_data SHALL load the granted channel's word, out_sel SHALL load g, and out_valid SHALL become 1 on the same edge; latency from input transfer to visible output is 1 cycle.
REQ-022 Sustained throughput SHALL be 1 word per cycle when out_ready=1.
REQ-023 If an output transfer occurs with no input transfer, out_valid SHALL go to 0 and out_data and out_sel SHALL hold their values.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold, and in_ready SHALL be all 0.
REQ-025 When no in_valid bit is set, in_ready SHALL be 0 and ptr SHALL hold.
REQ-026 The block SHALL NOT drop or duplicate words; sources keep in_data stable while in_valid=1 and in_ready=0.
REQ-027 out_sel SHALL only take values 0..CHANNELS-1.

Reset
REQ-028 While rst=1, out_valid=0, out_data=0, out_sel=0, ptr=CHANNELS-1 and in_ready=0, asynchronously and without waiting for clk.
REQ-029 An assertion of rst mid-stream SHALL discard any held output word.
REQ-030 The first round-robin grant after reset release SHALL go to channel 0 when its in_valid is set.

Verification (CHANNELS=4, WIDTH=8)
REQ-031 Round-robin: all four in_valid=1, data 0xA0/0xA1/0xA2/0xA3, out_ready=1, mode=0 -> out_sel sequence 0,1,2,3,0,... with out_data 0xA0,0xA1,0xA2,0xA3,0xA0, one word per cycle after a 1-cycle latency.
REQ-032 Fixed priority: in_valid=4'b1010, mode=1, out_ready=1 -> out_sel=1 on every cycle and in_ready[3] never asserted; switch to mode=0 -> next grant is 3, then 1.
REQ-033 Backpressure: out_valid=1 with out_data=0x55 and out_ready=0 for 5 cycles -> out_data stays 0x55 and in_ready=0000; out_ready=1 -> next word appears on the following edge with no gap.
REQ-034 Sparse traffic: only in_valid[2]=1 -> channel 2 is granted each cycle and ptr=2; then in_valid=4'b1100 -> grants 3,2,3,2.
REQ-035 Reset mid-stream: rst pulsed between clock edges while out_valid=1 -> out_valid=0 and out_data=0 immediately; after release with all in_valid set, the first out_sel is 0.
REQ-036 Drain: out_valid=1, in_valid=0000, out_ready=1 -> out_valid=0 next cycle and out_data holds its value.
